// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bus arbiter and other bus masters that need
// round-robin selection.
package reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  // Read data returned to a requester whose transfer timed out (sliced to DATA_WIDTH).
  localparam logic [63:0] ERR_RDATA = '1;

  // First set bit of req at or after ptr, wrapping modulo n; 0 when req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int unsigned        n);
    logic [IDX_W-1:0] idx;
    logic             found;
    int unsigned      j;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !found && req[j[IDX_W-1:0]]) begin
        idx   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_rr_pick.sv
// Combinational round-robin picker: rotate the request vector by ptr and priority-encode the
// first requester found.
module reg_rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    grant                  = rr_pick(req_ext, ptr, NUM_REQ);
    any                    = |req;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one reg_ctrl register bus between NUM_REQ requesters, with a
// per-transfer ready timeout so a silent slave cannot hang the bus.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_sel,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          req_err,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          m_sel,
  output logic                          m_wr,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_ready
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       rr_ptr;
  logic [7:0]             cnt;

  logic [IDX_W-1:0]       pick;
  logic                   any;
  logic                   pick_wr;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic [DATA_WIDTH-1:0]  pick_wdata;

  reg_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_sel),
    .ptr   (rr_ptr),
    .grant (pick),
    .any   (any)
  );

  // Select the picked requester's slice of the flattened request fields.
  always_comb begin
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_wr    = req_wr[i];
        pick_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      m_sel     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      req_ready <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant   <= pick;
            m_sel   <= 1'b1;
            m_wr    <= pick_wr;
            m_addr  <= pick_addr;
            m_wdata <= pick_wdata;
            cnt     <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (m_ready) begin
            m_sel     <= 1'b0;
            req_ready <= NUM_REQ'(1) << grant;
            req_err   <= 1'b0;
            req_rdata <= m_wr ? '0 : m_rdata;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            m_sel     <= 1'b0;
            req_ready <= NUM_REQ'(1) << grant;
            req_err   <= 1'b1;
            req_rdata <= ERR_RDATA[DATA_WIDTH-1:0];
            state     <= DONE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          req_ready <= '0;
          req_err   <= 1'b0;
          rr_ptr    <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter: single read, all-request round-robin,
// fairness, timeout, reset mid-transfer and stray slave ready pulses.
module tb_reg_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_sel;
  logic [3:0]  req_wr;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ready;
  logic        req_err;
  logic [15:0] req_rdata;
  logic        m_sel;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ready;

  int checks   = 0;
  int failures = 0;

  reg_bus_arbiter #(
    .NUM_REQ    (4),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .TIMEOUT    (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_sel   (req_sel),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .m_sel     (m_sel),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          pulses;
    int          n_sel;
    logic        got;
    logic [1:0]  exp_g;

    rst       = 1'b1;
    req_sel   = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_rdata   = '0;
    m_ready   = 1'b0;

    // Reset state
    #1;
    chk("rst_m_sel", 32'(m_sel), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_req_err", 32'(req_err), 32'h0);
    chk("rst_req_rdata", 32'(req_rdata), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single read from requester 0, slave ready on second ACCESS cycle
    req_sel       = 4'b0001;
    req_addr[7:0] = 8'h04;
    @(negedge clk);
    chk("rd_m_sel_c1", 32'(m_sel), 32'h1);
    chk("rd_m_addr", 32'(m_addr), 32'h04);
    chk("rd_m_wr", 32'(m_wr), 32'h0);
    @(negedge clk);
    chk("rd_m_sel_c2", 32'(m_sel), 32'h1);
    m_ready = 1'b1;
    m_rdata = 16'hBEEF;
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_rdata", 32'(req_rdata), 32'hBEEF);
    chk("rd_err", 32'(req_err), 32'h0);
    chk("rd_m_sel_off", 32'(m_sel), 32'h0);
    m_ready = 1'b0;
    m_rdata = '0;
    req_sel = '0;
    @(negedge clk);
    chk("rd_ready_clr", 32'(req_ready), 32'h0);

    // Stray m_ready while idle
    m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_idle_ready", 32'(req_ready), 32'h0);
      chk("stray_idle_m_sel", 32'(m_sel), 32'h0);
    end
    m_ready = 1'b0;

    // Reset mid-ACCESS (rr_ptr is 1 here, so 4'b1100 grants requester 2)
    req_sel  = 4'b1100;
    req_addr = {8'h33, 8'h22, 8'h11, 8'h00};
    @(negedge clk);
    chk("rm_m_sel", 32'(m_sel), 32'h1);
    chk("rm_m_addr", 32'(m_addr), 32'h22);
    #2 rst = 1'b1;
    #1;
    chk("rm_async_m_sel", 32'(m_sel), 32'h0);
    chk("rm_async_ready", 32'(req_ready), 32'h0);
    req_sel = 4'b1001;
    m_ready = 1'b1;
    @(negedge clk);
    chk("rm_held_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_regrant_sel", 32'(m_sel), 32'h1);
    chk("rm_regrant_addr", 32'(m_addr), 32'h00);
    @(negedge clk);
    chk("rm_regrant_ready", 32'(req_ready), 32'h1);
    req_sel = '0;
    m_ready = 1'b0;
    @(negedge clk);

    // All four requesters together from reset; m_ready held high throughout
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    req_sel  = 4'b1111;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    m_ready  = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("all_m_sel", 32'(m_sel), 32'h1);
      chk("all_m_addr", 32'(m_addr), 32'h10 + 32'(i));
      if (req_ready != 0) pulses++;
      @(negedge clk);
      chk("all_ready", 32'(req_ready), 32'h1 << i);
      if (req_ready != 0) pulses++;
      req_sel[i] = 1'b0;
      @(negedge clk);
      chk("all_idle_m_sel", 32'(m_sel), 32'h0);
      if (req_ready != 0) pulses++;
    end
    chk("all_pulse_count", 32'(pulses), 32'd4);

    // Fairness: req0 and req2 held continuously, stray m_ready in DONE/IDLE
    req_sel = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 1) ? 2'd2 : 2'd0;
      @(negedge clk);
      chk("fair_m_addr", 32'(m_addr), 32'h10 + 32'(exp_g));
      @(negedge clk);
      chk("fair_ready", 32'(req_ready), 32'h1 << exp_g);
      @(negedge clk);
      chk("fair_idle_ready", 32'(req_ready), 32'h0);
      chk("fair_idle_m_sel", 32'(m_sel), 32'h0);
      if (t == 7) req_sel = '0;
    end
    m_ready = 1'b0;

    // Timeout: requester 1 write, slave never ready (rr_ptr is 3, so grant 1)
    req_sel              = 4'b0010;
    req_wr               = 4'b0010;
    req_wdata[31:16]     = 16'h1234;
    n_sel                = 0;
    got                  = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        got = 1'b1;
      end else if (m_sel) begin
        n_sel++;
        if (n_sel == 1) begin
          chk("to_m_wr", 32'(m_wr), 32'h1);
          chk("to_m_wdata", 32'(m_wdata), 32'h1234);
        end
      end
    end
    chk("to_completed", 32'(got), 32'h1);
    chk("to_access_cycles", 32'(n_sel), 32'd15);
    chk("to_ready", 32'(req_ready), 32'h2);
    chk("to_err", 32'(req_err), 32'h1);
    chk("to_rdata", 32'(req_rdata), 32'hFFFF);
    chk("to_m_sel_off", 32'(m_sel), 32'h0);
    req_sel = '0;
    req_wr  = '0;
    @(negedge clk);
    chk("to_ready_clr", 32'(req_ready), 32'h0);
    chk("to_err_clr", 32'(req_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
